// File: rtl/nrisc_pc_stack.sv
// NRISC program counter with a call/return stack of {return PC, ULA flags}.
// Owns PC sequencing plus stack depth tracking and sticky stack errors.
module nrisc_pc_stack #(
  parameter int TAM   = 16,
  parameter int DEPTH = 8,
  parameter int FLAGW = 3,
  parameter logic [TAM-1:0] RST_VECTOR = '0,
  localparam int SPW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pc_op,
  input  logic [TAM-1:0]   target,
  input  logic [FLAGW-1:0] flags_in,
  input  logic             err_clr,
  output logic [TAM-1:0]   pc,
  output logic [FLAGW-1:0] flags_out,
  output logic             flags_restore,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_HOLD = 3'd1,
    OP_JUMP = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_BREL = 3'd5
  } op_e;

  typedef struct packed {
    logic [TAM-1:0]   ret_pc;
    logic [FLAGW-1:0] flags;
  } ent_t;

  ent_t mem [DEPTH];

  op_e            op;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic [TAM-1:0] pc_inc;
  logic           do_push;
  logic           do_pop;
  ent_t           top;

  assign op          = op_e'(pc_op);
  assign stack_full  = (sp == SPW'(DEPTH));
  assign stack_empty = (sp == '0);
  assign wr_idx      = sp[IW-1:0];
  assign rd_idx      = IW'(sp - SPW'(1));
  assign pc_inc      = pc + TAM'(1);
  assign top         = mem[rd_idx];

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    unique case (1'b1)
      (op == OP_CALL): do_push = !stack_full;
      (op == OP_RET):  do_pop  = !stack_empty;
      default: ;
    endcase
  end

  // Stack RAM is deliberately left unreset; only sp defines validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_idx] <= '{ret_pc: pc_inc, flags: flags_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RST_VECTOR;
      sp            <= '0;
      flags_out     <= '0;
      flags_restore <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      flags_restore <= 1'b0;
      // Clear first so a same-cycle error set below wins.
      if (err_clr) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end
      unique case (op)
        OP_INC:  pc <= pc_inc;
        OP_JUMP: pc <= target;
        OP_BREL: pc <= pc + target;
        OP_CALL: begin
          if (do_push) begin
            sp <= sp + SPW'(1);
            pc <= target;
          end else begin
            overflow_err <= 1'b1;
          end
        end
        OP_RET: begin
          if (do_pop) begin
            sp            <= sp - SPW'(1);
            pc            <= top.ret_pc;
            flags_out     <= top.flags;
            flags_restore <= 1'b1;
          end else begin
            underflow_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nrisc_pc_stack.md
Name: nrisc_pc_stack

Overview:
- Parametrised program-counter and call/return unit for the NRISC core.
- Replaces the ad-hoc PC register and fixed call stack with one block. It holds the PC, executes increment, hold, absolute jump, relative branch, call and return, and keeps a DEPTH-entry hardware stack of {return PC, ULA flags}.
- Sits between NRISC_CORE (which drives pc_op) and program memory (which consumes pc).
- Adds behaviour the old path lacked: full/empty detection, sticky overflow/underflow errors, and a flag-restore strobe.

Parameters:
- TAM, 16, data/address width of PC and target.
- DEPTH, 8, number of stack entries (≥2).
- FLAGW, 3, width of the ULA flag vector saved per call.
- RST_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  input  1  main clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_op  input  3  operation: 0 INC, 1 HOLD, 2 JUMP, 3 CALL, 4 RET, 5 BREL; 6 and 7 reserved.
- target  input  TAM  absolute address (JUMP, CALL) or two's-complement offset (BREL).
- flags_in  input  FLAGW  current ULA flags, pushed on CALL.
- err_clr  input  1  clears the sticky error bits.
- pc  output  TAM  current program counter (registered).
- flags_out  output  FLAGW  flags popped by the last successful RET (registered).
- flags_restore  output  1  one-cycle pulse in the cycle after a successful RET.
- sp  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- stack_full  output  1  sp == DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- overflow_err  output  1  sticky; set by a CALL attempted while full.
- underflow_err  output  1  sticky; set by a RET attempted while empty.

Behaviour:
- Reset (rst=1 at a clk edge): pc=RST_VECTOR, sp=0, flags_out=0, flags_restore=0, overflow_err=0, underflow_err=0. Stack RAM contents are not cleared; entries at or above sp are don't-care. rst has priority over every pc_op and over err_clr.
- All outputs are registered, with a single-cycle effect: pc_op sampled at edge N takes effect at edge N.
- INC: pc <= pc+1, modulo 2^TAM (0xFFFF+1 = 0x0000 at TAM=16).
- HOLD, 6, 7: pc unchanged; no stack activity.
- JUMP: pc <= target.
- BREL: pc <= pc+target, target sign-extended, result modulo 2^TAM; no overflow flagging.
- CALL, not full: mem[sp] <= {pc+1 (mod 2^TAM), flags_in}; sp <= sp+1; pc <= target.
- CALL, full: no write; sp and pc unchanged (the core re-issues or traps); overflow_err <= 1.
- RET, not empty: pc <= mem[sp-1].pc; flags_out <= mem[sp-1].flags; sp <= sp-1; flags_restore <= 1 for exactly one cycle.
- RET, empty: pc and sp unchanged; flags_out unchanged; flags_restore stays 0; underflow_err <= 1.
- flags_restore is 0 in every cycle not immediately following a successful RET.
- Error bits are sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the set wins (bit ends at 1).
- CALL that fills the stack (sp from DEPTH-1 to DEPTH) is legal; stack_full asserts the following cycle.
- Back-to-back CALL then RET in consecutive cycles must return to the just-pushed address; the pop reads the entry written on the previous edge.
- Reset mid-call-chain discards all entries (sp=0). A RET after reset underflows.

Test Plan:
- Reset then 3×INC with RST_VECTOR=0x0100 -> pc 0x0100, 0x0101, 0x0102, 0x0103; sp=0, stack_empty=1.
- pc=0x0010, CALL target=0x0200, flags_in=3'b101; next cycle RET -> pc 0x0200, then 0x0011; flags_out=3'b101; flags_restore high one cycle only; sp 0→1→0.
- DEPTH=8: 8 nested CALLs with distinct targets -> stack_full=1, sp=8. 9th CALL -> pc unchanged, overflow_err=1. 8 RETs unwind in LIFO order to the original return addresses.
- Empty stack, RET -> pc unchanged, underflow_err=1, flags_restore=0. err_clr=1 alone -> error cleared. err_clr together with another empty RET -> underflow_err stays 1.
- pc=0xFFFF INC -> 0x0000. pc=0x0005 BREL target=0xFFFD -> 0x0002. pc=0xFFFE BREL target=0x0004 -> 0x0002.
- Two CALLs (sp=2), then rst=1 concurrent with RET -> pc=RST_VECTOR, sp=0, errors 0, flags_restore=0. Next RET -> underflow_err=1.
